// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the fetch sequencer, the instruction memory and the decode stage.
// Valid/ready rules:
//   - Memory side: mem_req is the valid, and mem_ack is the ready/complete strobe.
//     mem_addr holds while mem_req=1 and mem_ack=0. mem_rdata is meaningful only with mem_ack.
//   - Decode side: if_valid is the valid, and !stall is the ready. The slot transfers when
//     if_valid=1 and stall=0.
interface fetch_sequencer_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        fetch_error;

  modport master (
    input  stall, redirect_valid, redirect_pc, mem_ack, mem_rdata,
    output mem_req, mem_addr, if_valid, if_pc, if_instr, fetch_error
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, mem_ack, mem_rdata,
    input  mem_req, mem_addr, if_valid, if_pc, if_instr, fetch_error
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: single IF/ID slot, redirect with drain of an in-flight request, and a sticky timeout.
// Optional macro FETCH_PERF_CNT_EN adds the fetch_count and stall_count performance counters.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_sequencer_if.master     bus,
  output logic [1:0]            o_dbg_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           fetch_count,
  output logic [31:0]           stall_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_drain_addr;
  logic [7:0]  r_wait_cnt;
  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_instr;
  logic        r_error;

  logic        w_mem_req;
  logic [31:0] w_mem_addr;
  logic        w_redirect;
  logic        w_wait_pend;
  logic        w_timeout;
  logic        w_load;
  logic [31:0] w_redirect_tgt;

  assign w_redirect     = bus.redirect_valid && (r_state != ST_ERR);
  assign w_redirect_tgt = bus.redirect_pc & 32'hFFFF_FFFC;
  assign w_wait_pend    = w_mem_req && !bus.mem_ack;
  // A redirect restarts the wait window, so it also masks the timeout.
  assign w_timeout      = w_wait_pend && !w_redirect && (r_wait_cnt == 8'(TIMEOUT - 1));
  assign w_load         = (r_state == ST_REQ) && w_mem_req && bus.mem_ack && !bus.redirect_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (w_redirect)     w_state_nxt = w_wait_pend ? ST_DRAIN : ST_REQ;
        else if (w_timeout) w_state_nxt = ST_ERR;
      end
      ST_DRAIN: begin
        if (bus.mem_ack)    w_state_nxt = ST_REQ;
        else if (w_timeout) w_state_nxt = ST_ERR;
      end
      default:  w_state_nxt = ST_ERR;
    endcase
  end

  always_comb begin
    w_mem_req  = 1'b0;
    w_mem_addr = r_pc;
    case (r_state)
      ST_REQ:   w_mem_req = !r_if_valid || !bus.stall;
      ST_DRAIN: begin
        w_mem_req  = 1'b1;
        w_mem_addr = r_drain_addr;
      end
      default:  w_mem_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc         <= RESET_PC;
      r_drain_addr <= 32'h0;
      r_wait_cnt   <= 8'h0;
      r_error      <= 1'b0;
    end else begin
      if (w_redirect)  r_pc <= w_redirect_tgt;
      else if (w_load) r_pc <= r_pc + 32'd4;
      // The abandoned address is remembered so the bus stays stable until its ack.
      if (r_state == ST_REQ && w_redirect && w_wait_pend) r_drain_addr <= r_pc;
      if (w_redirect || !w_mem_req || bus.mem_ack) r_wait_cnt <= 8'h0;
      else                                          r_wait_cnt <= r_wait_cnt + 8'd1;
      if (w_timeout) r_error <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_if_valid <= 1'b0;
      r_if_pc    <= 32'h0;
      r_if_instr <= 32'h0;
    end else if (w_redirect || w_timeout) begin
      r_if_valid <= 1'b0;
    end else if (w_load) begin
      r_if_valid <= 1'b1;
      r_if_pc    <= r_pc;
      r_if_instr <= bus.mem_rdata;
    end else if (r_if_valid && !bus.stall) begin
      r_if_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_count <= 32'h0;
      r_stall_count <= 32'h0;
    end else begin
      if (w_load)                   r_fetch_count <= r_fetch_count + 32'd1;
      if (r_if_valid && bus.stall)  r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;
`endif

  assign bus.mem_req     = w_mem_req;
  assign bus.mem_addr    = w_mem_addr;
  assign bus.if_valid    = r_if_valid;
  assign bus.if_pc       = r_if_pc;
  assign bus.if_instr    = r_if_instr;
  assign bus.fetch_error = r_error;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a main DUT with RESET_PC=0 and a second DUT that starts near the top of the address space.
module tb_fetch_sequencer;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int test_cnt = 0;
  int fail_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  logic auto_ack;
  logic man_ack;
  logic [1:0] dbg0;
  logic [1:0] dbg1;

  fetch_sequencer_if bus0 ();
  fetch_sequencer_if bus1 ();

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign bus0.mem_ack        = auto_ack ? bus0.mem_req : man_ack;
  assign bus0.mem_rdata      = instr_of(bus0.mem_addr);
  assign bus1.stall          = 1'b0;
  assign bus1.redirect_valid = 1'b0;
  assign bus1.redirect_pc    = 32'h0;
  assign bus1.mem_ack        = bus1.mem_req;
  assign bus1.mem_rdata      = instr_of(bus1.mem_addr);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fc0, sc0, fc1, sc1;
`endif

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus0),
    .o_dbg_state (dbg0)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count (fc0),
    .stall_count (sc0)
`endif
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFF8), .TIMEOUT(16)) u_dut_wrap (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus1),
    .o_dbg_state (dbg1)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count (fc1),
    .stall_count (sc1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0;
    bus0.stall = 1'b0;
    bus0.redirect_valid = 1'b0;
    bus0.redirect_pc = 32'h0;
    auto_ack = 1'b1;
    man_ack = 1'b0;

    // Reset state
    #1;
    check("rst_mem_req", {31'h0, bus0.mem_req}, 32'h0);
    check("rst_if_valid", {31'h0, bus0.if_valid}, 32'h0);
    check("rst_if_pc", bus0.if_pc, 32'h0);
    check("rst_if_instr", bus0.if_instr, 32'h0);
    check("rst_fetch_error", {31'h0, bus0.fetch_error}, 32'h0);
    check("rst_state", {30'h0, dbg0}, {30'h0, S_IDLE});
    tick();
    reset = 1'b1;
    #1;
    check("idle_bubble_mem_req", {31'h0, bus0.mem_req}, 32'h0);

    // Zero-wait back-to-back fetch
    tick();
    check("first_req", {31'h0, bus0.mem_req}, 32'h1);
    check("first_addr", bus0.mem_addr, 32'h0);
    check("first_slot_empty", {31'h0, bus0.if_valid}, 32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    tick();
    exp_v = exp_q.pop_front();
    check("seq_if_pc0", bus0.if_pc, exp_v);
    check("seq_if_valid0", {31'h0, bus0.if_valid}, 32'h1);
    check("seq_if_instr0", bus0.if_instr, instr_of(32'h0));
    check("wrap_pc0", bus1.if_pc, 32'hFFFF_FFF8);
    tick();
    exp_v = exp_q.pop_front();
    check("seq_if_pc1", bus0.if_pc, exp_v);
    check("wrap_pc1", bus1.if_pc, 32'hFFFF_FFFC);
    tick();
    exp_v = exp_q.pop_front();
    check("seq_if_pc2", bus0.if_pc, exp_v);
    check("wrap_pc2", bus1.if_pc, 32'h0000_0000);
    check("wrap_instr2", bus1.if_instr, instr_of(32'h0));

    // Stall holds slot for three cycles
    bus0.stall = 1'b1;
    #1;
    check("stall_mem_req0", {31'h0, bus0.mem_req}, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall_hold_pc", bus0.if_pc, 32'h8);
      check("stall_hold_instr", bus0.if_instr, instr_of(32'h8));
      check("stall_mem_req", {31'h0, bus0.mem_req}, 32'h0);
    end
    tick();
    bus0.stall = 1'b0;
    #1;
    check("unstall_pc_hold", bus0.if_pc, 32'h8);
    check("unstall_req", {31'h0, bus0.mem_req}, 32'h1);
    check("unstall_addr", bus0.mem_addr, 32'hC);
    tick();
    check("after_stall_pc", bus0.if_pc, 32'hC);

    // Redirect with pending request on address 16 -> drain
    auto_ack = 1'b0;
    man_ack = 1'b0;
    bus0.redirect_valid = 1'b1;
    bus0.redirect_pc = 32'h0000_0041;
    #1;
    check("redir_req_addr", bus0.mem_addr, 32'h10);
    tick();
    bus0.redirect_valid = 1'b0;
    #1;
    check("drain_state", {30'h0, dbg0}, {30'h0, S_DRAIN});
    check("drain_addr0", bus0.mem_addr, 32'h10);
    check("drain_req", {31'h0, bus0.mem_req}, 32'h1);
    check("drain_slot_empty", {31'h0, bus0.if_valid}, 32'h0);
    tick();
    man_ack = 1'b1;
    #1;
    check("drain_addr1", bus0.mem_addr, 32'h10);
    check("drain_state1", {30'h0, dbg0}, {30'h0, S_DRAIN});
    tick();
    man_ack = 1'b0;
    #1;
    check("post_drain_state", {30'h0, dbg0}, {30'h0, S_REQ});
    check("drain_data_dropped", {31'h0, bus0.if_valid}, 32'h0);
    check("post_drain_addr", bus0.mem_addr, 32'h40);
    auto_ack = 1'b1;
    tick();
    check("redir_if_pc", bus0.if_pc, 32'h40);
    check("redir_if_instr", bus0.if_instr, instr_of(32'h40));
    check("redir_if_valid", {31'h0, bus0.if_valid}, 32'h1);

    // Redirect beats stall
    bus0.stall = 1'b1;
    bus0.redirect_valid = 1'b1;
    bus0.redirect_pc = 32'h0000_0103;
    #1;
    check("redir_stall_req", {31'h0, bus0.mem_req}, 32'h0);
    tick();
    bus0.redirect_valid = 1'b0;
    bus0.stall = 1'b0;
    #1;
    check("redir_stall_flush", {31'h0, bus0.if_valid}, 32'h0);
    check("redir_stall_addr", bus0.mem_addr, 32'h100);
    check("redir_stall_state", {30'h0, dbg0}, {30'h0, S_REQ});
    tick();
    check("redir_stall_pc", bus0.if_pc, 32'h100);

    // Redirect in the same cycle as an ack discards that data
    bus0.redirect_valid = 1'b1;
    bus0.redirect_pc = 32'h0000_0200;
    #1;
    check("redir_ack_req", {31'h0, bus0.mem_req}, 32'h1);
    tick();
    bus0.redirect_valid = 1'b0;
    #1;
    check("redir_ack_discard", {31'h0, bus0.if_valid}, 32'h0);
    check("redir_ack_state", {30'h0, dbg0}, {30'h0, S_REQ});
    check("redir_ack_addr", bus0.mem_addr, 32'h200);
    tick();
    check("redir_ack_pc", bus0.if_pc, 32'h200);

    // Timeout after 16 un-acked request cycles
    auto_ack = 1'b0;
    man_ack = 1'b0;
    #1;
    check("to_req_start", {31'h0, bus0.mem_req}, 32'h1);
    check("to_addr_start", bus0.mem_addr, 32'h204);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("to_wait_req", {31'h0, bus0.mem_req}, 32'h1);
      check("to_wait_addr", bus0.mem_addr, 32'h204);
      check("to_wait_err", {31'h0, bus0.fetch_error}, 32'h0);
    end
    tick();
    check("to_error", {31'h0, bus0.fetch_error}, 32'h1);
    check("to_mem_req", {31'h0, bus0.mem_req}, 32'h0);
    check("to_if_valid", {31'h0, bus0.if_valid}, 32'h0);
    check("to_state", {30'h0, dbg0}, {30'h0, S_ERR});
    bus0.redirect_valid = 1'b1;
    bus0.redirect_pc = 32'h0000_0300;
    man_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("err_state_hold", {30'h0, dbg0}, {30'h0, S_ERR});
      check("err_mem_req", {31'h0, bus0.mem_req}, 32'h0);
      check("err_sticky", {31'h0, bus0.fetch_error}, 32'h1);
      check("err_if_valid", {31'h0, bus0.if_valid}, 32'h0);
    end
    bus0.redirect_valid = 1'b0;
    man_ack = 1'b0;

    // Reset leaves ERR and restarts at RESET_PC
    reset = 1'b0;
    #1;
    check("err_reset_flag", {31'h0, bus0.fetch_error}, 32'h0);
    check("err_reset_state", {30'h0, dbg0}, {30'h0, S_IDLE});
    #1;
    reset = 1'b1;
    auto_ack = 1'b1;
    tick();
    check("restart_addr", bus0.mem_addr, 32'h0);
    check("restart_req", {31'h0, bus0.mem_req}, 32'h1);
    tick();
    check("restart_pc0", bus0.if_pc, 32'h0);
    tick();
    check("restart_pc1", bus0.if_pc, 32'h4);

    // Reset mid-request: outputs clear at once, late ack ignored
    auto_ack = 1'b0;
    man_ack = 1'b0;
    #1;
    check("mid_req", {31'h0, bus0.mem_req}, 32'h1);
    check("mid_addr", bus0.mem_addr, 32'h8);
    reset = 1'b0;
    #1;
    check("async_mem_req", {31'h0, bus0.mem_req}, 32'h0);
    check("async_mem_addr", bus0.mem_addr, 32'h0);
    check("async_if_valid", {31'h0, bus0.if_valid}, 32'h0);
    check("async_if_pc", bus0.if_pc, 32'h0);
    check("async_if_instr", bus0.if_instr, 32'h0);
    check("async_fetch_error", {31'h0, bus0.fetch_error}, 32'h0);
    #1;
    reset = 1'b1;
    man_ack = 1'b1;
    #1;
    check("late_ack_idle_req", {31'h0, bus0.mem_req}, 32'h0);
    check("late_ack_idle_state", {30'h0, dbg0}, {30'h0, S_IDLE});
    tick();
    check("late_ack_ignored", {31'h0, bus0.if_valid}, 32'h0);
    check("late_ack_state", {30'h0, dbg0}, {30'h0, S_REQ});
    check("late_ack_addr", bus0.mem_addr, 32'h0);
    auto_ack = 1'b1;
    man_ack = 1'b0;
    tick();
    check("rerun_if_pc", bus0.if_pc, 32'h0);
    check("rerun_if_instr", bus0.if_instr, instr_of(32'h0));
    check("rerun_if_valid", {31'h0, bus0.if_valid}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
